// File: rtl/rggen_spi_pkg.sv
// Shared types and constants for the rggen SPI bus sequencer.
// Access codes, status byte layout and frame state encoding.
package rggen_spi_pkg;

  localparam logic [1:0] ACCESS_READ  = 2'b10;
  localparam logic [1:0] ACCESS_WRITE = 2'b11;

  localparam int STAT_DONE_BIT = 7;
  localparam int STAT_DROP_BIT = 6;

  localparam int ADDRESS_WIDTH_DEFAULT = 8;
  localparam int BUS_WIDTH_DEFAULT     = 32;

  function automatic int num_bytes(input int width);
    return (width + 7) / 8;
  endfunction

  localparam int ADDRESS_BYTES =
    num_bytes(ADDRESS_WIDTH_DEFAULT);
  localparam int DATA_BYTES =
    BUS_WIDTH_DEFAULT / 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_WDATA,
    ST_TURN,
    ST_STAT,
    ST_RDATA,
    ST_DONE
  } frame_state_t;

  typedef enum logic {
    BUS_IDLE,
    BUS_WAIT
  } bus_state_t;

endpackage

// File: rtl/rggen_spi_sync_edge.sv
// Oversampling synchronizer for SCLK/SS_N/MOSI.
// Emits single-cycle SCLK and SS_N edge strobes.
module rggen_spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sclk,
  input  logic i_ss_n,
  input  logic i_mosi,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic ss_active,
  output logic ss_fall,
  output logic ss_rise,
  output logic mosi_s
);

  localparam int TOP = SYNC_STAGES - 1;

  logic [TOP:0] sclk_q;
  logic [TOP:0] ss_n_q;
  logic [TOP:0] mosi_q;
  logic         sclk_d;
  logic         ss_n_d;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sclk_q <= '0;
      ss_n_q <= '1;
      mosi_q <= '0;
      sclk_d <= 1'b0;
      ss_n_d <= 1'b1;
    end else begin
      sclk_q <= {sclk_q[TOP-1:0], i_sclk};
      ss_n_q <= {ss_n_q[TOP-1:0], i_ss_n};
      mosi_q <= {mosi_q[TOP-1:0], i_mosi};
      sclk_d <= sclk_q[TOP];
      ss_n_d <= ss_n_q[TOP];
    end
  end

  assign sclk_rise = sclk_q[TOP] & ~sclk_d;
  assign sclk_fall = ~sclk_q[TOP] & sclk_d;
  assign ss_active = ~ss_n_q[TOP];
  assign ss_fall   = ~ss_n_q[TOP] & ss_n_d;
  assign ss_rise   = ss_n_q[TOP] & ~ss_n_d;
  assign mosi_s    = mosi_q[TOP];

endmodule

// File: rtl/rggen_spi_bus_sequencer.sv
// SPI-slave frame engine driving one rggen bus access per frame.
// Returns a status byte and, for reads, the read data on MISO.
module rggen_spi_bus_sequencer
  import rggen_spi_pkg::*;
#(
  parameter int ADDRESS_WIDTH    = 8,
  parameter int BUS_WIDTH        = 32,
  parameter int SYNC_STAGES      = 2,
  parameter int TURNAROUND_BYTES = 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_sclk,
  input  logic                   i_ss_n,
  input  logic                   i_mosi,
  output logic                   o_miso,
  output logic                   o_bus_valid,
  output logic [1:0]             o_bus_access,
  output logic [ADDRESS_WIDTH-1:0] o_bus_address,
  output logic [BUS_WIDTH-1:0]   o_bus_write_data,
  output logic [BUS_WIDTH/8-1:0] o_bus_strobe,
  input  logic                   i_bus_ready,
  input  logic [1:0]             i_bus_status,
  input  logic [BUS_WIDTH-1:0]   i_bus_read_data
);

  localparam int AB = num_bytes(ADDRESS_WIDTH);
  localparam int DB = BUS_WIDTH / 8;
  localparam int AW8 = AB * 8;
  localparam logic [7:0] A_LAST = 8'(AB - 1);
  localparam logic [7:0] D_LAST = 8'(DB - 1);
  localparam logic [7:0] T_LAST =
    8'(TURNAROUND_BYTES - 1);

  logic sclk_rise;
  logic sclk_fall;
  logic ss_active;
  logic ss_fall;
  logic ss_rise;
  logic mosi_s;

  rggen_spi_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_sclk    (i_sclk),
    .i_ss_n    (i_ss_n),
    .i_mosi    (i_mosi),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .ss_active (ss_active),
    .ss_fall   (ss_fall),
    .ss_rise   (ss_rise),
    .mosi_s    (mosi_s)
  );

  frame_state_t state;
  bus_state_t   bus_state;

  logic [2:0]           bit_cnt;
  logic [7:0]           byte_cnt;
  logic                 is_write;
  logic                 dropped;
  logic                 load_pending;
  logic [6:0]           rx_shift;
  logic [7:0]           rx_byte;
  logic [7:0]           tx_shift;
  logic [7:0]           stat_byte;
  logic [AW8-1:0]       addr_sh;
  logic [AW8-1:0]       addr_next;
  logic [AW8-1:0]       issue_addr;
  logic [AW8+7:0]       addr_cat;
  logic [BUS_WIDTH-1:0] wdata_sh;
  logic [BUS_WIDTH-1:0] wdata_next;
  logic [BUS_WIDTH+7:0] wdata_cat;
  logic [BUS_WIDTH-1:0] rd_snap;
  logic [BUS_WIDTH-1:0] resp_rdata;
  logic [1:0]           resp_status;
  logic                 resp_done;
  logic                 done_eff;
  logic                 byte_done;
  logic                 issue;

  assign rx_byte    = {rx_shift, mosi_s};
  assign addr_cat   = {addr_sh, rx_byte};
  assign addr_next  = addr_cat[AW8-1:0];
  assign wdata_cat  = {wdata_sh, rx_byte};
  assign wdata_next = wdata_cat[BUS_WIDTH-1:0];
  assign issue_addr = is_write ? addr_sh : addr_next;

  assign byte_done = ss_active && sclk_rise &&
                     (state != ST_IDLE) &&
                     (bit_cnt == 3'd7);

  assign issue = byte_done && (
    (state == ST_ADDR && byte_cnt == A_LAST &&
     !is_write) ||
    (state == ST_WDATA && byte_cnt == D_LAST));

  // A dropped frame never reports a completion.
  assign done_eff = resp_done & ~dropped;

  always_comb begin
    stat_byte = '0;
    stat_byte[STAT_DONE_BIT] = done_eff;
    stat_byte[STAT_DROP_BIT] = dropped;
    if (done_eff) stat_byte[1:0] = resp_status;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= ST_IDLE;
      bit_cnt      <= '0;
      byte_cnt     <= '0;
      is_write     <= 1'b0;
      dropped      <= 1'b0;
      load_pending <= 1'b0;
      rx_shift     <= '0;
      tx_shift     <= '0;
      addr_sh      <= '0;
      wdata_sh     <= '0;
      rd_snap      <= '0;
      o_miso       <= 1'b0;
    end else if (ss_rise) begin
      state        <= ST_IDLE;
      bit_cnt      <= '0;
      byte_cnt     <= '0;
      load_pending <= 1'b0;
      o_miso       <= 1'b0;
    end else if (ss_fall) begin
      state        <= ST_CMD;
      bit_cnt      <= '0;
      byte_cnt     <= '0;
      dropped      <= 1'b0;
      load_pending <= 1'b0;
      tx_shift     <= '0;
      o_miso       <= 1'b0;
    end else if (ss_active && state != ST_IDLE) begin
      if (sclk_rise) begin
        rx_shift <= rx_byte[6:0];
        bit_cnt  <= bit_cnt + 3'd1;
      end
      if (byte_done) begin
        load_pending <= 1'b1;
        unique case (state)
          ST_CMD: begin
            is_write <= rx_byte[7];
            byte_cnt <= '0;
            state    <= ST_ADDR;
          end
          ST_ADDR: begin
            addr_sh <= addr_next;
            if (byte_cnt == A_LAST) begin
              byte_cnt <= '0;
              if (is_write) begin
                state <= ST_WDATA;
              end else begin
                dropped <= o_bus_valid;
                state   <= ST_TURN;
              end
            end else begin
              byte_cnt <= byte_cnt + 8'd1;
            end
          end
          ST_WDATA: begin
            wdata_sh <= wdata_next;
            if (byte_cnt == D_LAST) begin
              byte_cnt <= '0;
              dropped  <= o_bus_valid;
              state    <= ST_TURN;
            end else begin
              byte_cnt <= byte_cnt + 8'd1;
            end
          end
          ST_TURN: begin
            if (byte_cnt == T_LAST) begin
              byte_cnt <= '0;
              state    <= ST_STAT;
            end else begin
              byte_cnt <= byte_cnt + 8'd1;
            end
          end
          ST_STAT: begin
            byte_cnt <= '0;
            state    <= is_write ? ST_DONE
                                 : ST_RDATA;
          end
          ST_RDATA: begin
            if (byte_cnt == D_LAST) begin
              byte_cnt <= '0;
              state    <= ST_DONE;
            end else begin
              byte_cnt <= byte_cnt + 8'd1;
            end
          end
          default: ;
        endcase
      end
      if (sclk_fall) begin
        if (load_pending) begin
          load_pending <= 1'b0;
          unique case (state)
            ST_STAT: begin
              // Completion is frozen here for the rest of the frame.
              o_miso   <= stat_byte[7];
              tx_shift <= {stat_byte[6:0], 1'b0};
              rd_snap  <= done_eff ? resp_rdata
                                   : '0;
            end
            ST_RDATA: begin
              o_miso   <= rd_snap[BUS_WIDTH-1];
              tx_shift <= {rd_snap[BUS_WIDTH-2 -: 7],
                           1'b0};
              rd_snap  <= rd_snap << 8;
            end
            default: begin
              o_miso   <= 1'b0;
              tx_shift <= '0;
            end
          endcase
        end else begin
          o_miso   <= tx_shift[7];
          tx_shift <= {tx_shift[6:0], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bus_state        <= BUS_IDLE;
      o_bus_valid      <= 1'b0;
      o_bus_access     <= '0;
      o_bus_address    <= '0;
      o_bus_write_data <= '0;
      o_bus_strobe     <= '0;
      resp_done        <= 1'b0;
      resp_status      <= '0;
      resp_rdata       <= '0;
    end else begin
      unique case (bus_state)
        BUS_IDLE: begin
          if (issue) begin
            bus_state     <= BUS_WAIT;
            o_bus_valid   <= 1'b1;
            o_bus_access  <= is_write ? ACCESS_WRITE
                                      : ACCESS_READ;
            o_bus_address <=
              issue_addr[ADDRESS_WIDTH-1:0];
            o_bus_write_data <= is_write ? wdata_next
                                         : '0;
            o_bus_strobe  <= is_write ? '1 : '0;
            resp_done     <= 1'b0;
            resp_status   <= '0;
          end
        end
        BUS_WAIT: begin
          if (i_bus_ready) begin
            bus_state   <= BUS_IDLE;
            o_bus_valid <= 1'b0;
            resp_done   <= 1'b1;
            resp_status <= i_bus_status;
            resp_rdata  <= i_bus_read_data;
          end
        end
        default: bus_state <= BUS_IDLE;
      endcase
    end
  end

endmodule

// File: doc/rggen_spi_bus_sequencer.md
Name: rggen_spi_bus_sequencer

Overview:
SPI-slave protocol engine that sequences the rggen register bus behind the SPI adapter. It oversamples SCLK/SS_N/MOSI in the system clock domain and decodes command, address and write-data frames. It issues exactly one rggen bus transaction per frame, holding valid until ready. It then shifts a status byte and read data back on MISO.

Parameters:
ADDRESS_WIDTH, 8, bus byte address width; sent as ceil(ADDRESS_WIDTH/8) bytes, MSB first, unused pad bits ignored.
BUS_WIDTH, 32, data width; multiple of 8.
SYNC_STAGES, 2, synchronizer depth on i_sclk/i_ss_n/i_mosi (>=2).
TURNAROUND_BYTES, 1, dummy bytes between request and status byte (>=1).

Ports:
i_clk  input  1  system clock; must be >= 8x SCLK frequency.
i_rst  input  1  asynchronous, active-high reset.
i_sclk  input  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
i_ss_n  input  1  SPI slave select, active low.
i_mosi  input  1  SPI data in.
o_miso  output  1  SPI data out.
o_bus_valid  output  1  rggen bus request valid.
o_bus_access  output  2  2'b10 read, 2'b11 write.
o_bus_address  output  ADDRESS_WIDTH  byte address.
o_bus_write_data  output  BUS_WIDTH  write data.
o_bus_strobe  output  BUS_WIDTH/8  byte strobes; all ones on write, all zeros on read.
i_bus_ready  input  1  transaction complete.
i_bus_status  input  2  response status (00 OKAY, others error).
i_bus_read_data  input  BUS_WIDTH  read data, valid with ready.

Behaviour:
- Reset values: o_miso=0, o_bus_valid=0, o_bus_access=0, o_bus_address=0, o_bus_write_data=0, o_bus_strobe=0. Frame FSM=IDLE; bus FSM=IDLE; response latch cleared.
- Synchronization: SCLK rise/fall are edge-detected on the synchronized SCLK. MOSI is sampled on the detected rise. MISO is updated on the detected fall. When SS_N falls, MISO presents bit7 of byte 0, which is 0.
- Frame FSM states: IDLE, CMD, ADDR, WDATA, TURN, STAT, RDATA, DONE. The shared bit counter runs 0..7; the byte counter is per state.
- IDLE->CMD on SS_N fall.
- CMD: 1 byte; bit7=1 selects write, 0 selects read; bits[6:0] ignored. CMD->ADDR after 8 bits.
- ADDR: address bytes. Then ->WDATA for a write, or issue the read and ->TURN.
- WDATA: BUS_WIDTH/8 bytes, MSB first. After the last bit, issue the write and ->TURN.
- TURN: TURNAROUND_BYTES bytes; MISO=0; MOSI ignored. ->STAT.
- STAT: 1 byte. bit7=done, bit6=drop, bits[5:2]=0, bits[1:0]=latched status. ->RDATA for a read, ->DONE for a write.
- RDATA: BUS_WIDTH/8 bytes, MSB first. Value is the latched read data if done=1, else all zeros. ->DONE.
- DONE: MOSI ignored, MISO=0, until SS_N rises.
- SS_N rise in any state ->IDLE, with counters cleared. If this happens before the issue point, no bus transaction occurs.
- Bus FSM:
  - On issue: address, access, data and strobe are registered and o_bus_valid=1 on the next cycle.
  - Valid and payload stay stable until a cycle where i_bus_ready=1. That same cycle latches status and read data and sets done.
  - The next cycle has valid=0.
  - If SS_N aborts mid-transaction, valid still holds until ready, because bus protocol requires completion.
- Done sampling: the done/status value driven on MISO is captured at the SCLK fall that launches STAT bit7. A response arriving later reports done=0 for the whole status and data bytes. The bus transaction still completes and its result is discarded.
- Busy drop: if the bus FSM is still busy (from an aborted frame) at the issue point, the new transaction is not issued. The status byte reports drop=1, done=0.
- Simultaneous events: SS_N rise on the same cycle as an SCLK edge — SS_N wins and the edge is ignored. Ready on the same cycle as the issue of the next frame cannot occur, because issue requires bus FSM IDLE.
- Reset mid-frame or mid-transaction: all state clears immediately (asynchronous) and valid drops.

Decomposition:
- Package rggen_spi_pkg holds:
  - access codes (READ=2'b10, WRITE=2'b11);
  - status byte bit positions;
  - frame state encoding;
  - localparams ADDRESS_BYTES and DATA_BYTES.
- Sub-module rggen_spi_sync_edge: SYNC_STAGES synchronizer for SCLK/SS_N/MOSI, producing sclk_rise, sclk_fall, ss_active and mosi_s.

Test Plan:
- Write: SS_N low; bytes 0x80, 0x24, 0xDEADBEEF; 1 dummy; ready after 3 clk with status 00 -> bus valid, access 11, addr 0x24, wdata 0xDEADBEEF, strobe 0xF; STAT byte on MISO = 0x80.
- Read: bytes 0x00, 0x10; bus returns 0x12345678, status 00, 2 clk after valid -> addr 0x10, access 10, strobe 0; MISO after dummy = 0x80, 0x12, 0x34, 0x56, 0x78.
- Late response: read with ready held off until after the STAT bit7 launch -> STAT=0x00, data 0x00000000; valid held until ready; next frame works normally.
- Error status: write with status 2'b10 -> STAT=0x82.
- Abort: SS_N rises after 4 address bits -> no o_bus_valid. Abort after issue with ready pending, then immediately a new read frame -> first valid completes; new frame STAT=0x40 and no second issue.
- Reset: assert i_rst while valid=1 mid-frame -> all outputs 0 within the same cycle; the next full write frame completes correctly.
